aes_dec_key_schedule: RTL and testbench
=======================================

Name: aes_dec_key_schedule

Overview:
- AES-128 key-expansion engine for the decryption datapath.
- Expands a 128-bit cipher key into 11 round keys, one per cycle, and stores them.
- Streams the stored keys in reverse order (round 10 down to round 0) to the AddRoundKey stage that consumes the inverse-substitution output.
- Uses a valid/ready handshake so the inverse-round controller can stall it.

Parameters:
- NR, 10, number of rounds; only 10 (AES-128) supported; any other value is an elaboration error.
- CLEAR_ON_LOAD, 1, when 1 the round-key store is zeroed on reset and on key_load; when 0 the store is not cleared.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- key_load  in  1  single-cycle pulse; captures key_in.
- key_in  in  128  cipher key; [127:120] is FIPS-197 byte 0.
- key_ready  out  1  all 11 round keys valid.
- dec_start  in  1  pulse; starts one reverse key stream.
- rk_valid  out  1  rk_out / rk_round valid.
- rk_ready  in  1  consumer accepts the current key.
- rk_out  out  128  round key, same byte order as key_in.
- rk_round  out  4  round index of rk_out (10..0).
- busy  out  1  high in EXPAND or STREAM.

Behaviour:
- Reset: all outputs are 0; state IDLE; round counter and Rcon index are 0.
- States and transitions:
  - IDLE: key_load -> EXPAND.
  - EXPAND: after writing rk[10] -> READY.
  - READY: dec_start -> STREAM.
  - STREAM: handshake on round 0 -> READY.
- key_load accepted in any state; it restarts expansion. Cycle of key_load: key_in is written to rk[0]; key_ready=0; rk_valid=0.
- EXPAND: one round key per cycle.
  - w4 = w0 ^ SubWord(RotWord(w3)) ^ {Rcon,24'h0}; w5 = w1^w4; w6 = w2^w5; w7 = w3^w6.
  - Rcon sequence: 01,02,04,08,10,20,40,80,1b,36.
  - rk[1]..rk[10] are written on cycles 1..10 after key_load.
  - key_ready=1 from cycle 11; it stays high until the next key_load.
- dec_start is honoured only in READY; it is ignored in IDLE, EXPAND and STREAM.
  - If key_load and dec_start are high in the same cycle, key_load wins.
- STREAM:
  - The cycle after dec_start: rk_valid=1, rk_round=10, rk_out=rk[10].
  - On each rk_valid&rk_ready: if rk_round>0 the next cycle presents rk_round-1; if rk_round==0, rk_valid=0 next cycle and state returns to READY.
  - rk_valid=1 with rk_ready=0: rk_out and rk_round hold stable.
  - rk_valid never drops without a handshake, except on key_load or reset.
- Repeated dec_start in READY replays the same 11 keys; no re-expansion is needed.
- key_load mid-STREAM: rk_valid=0 next cycle; the partial stream is abandoned; expansion restarts.
- Reset mid-operation: immediate return to the reset values.
- rk_out is registered, with no combinational path from rk_ready to rk_out.
- Peak throughput: one key per cycle.

Decomposition:
- Shared package aes_pkg holds:
  - AES_NR = 10 and AES_RK_W = 128.
  - Rcon table function.
  - State enum {IDLE, EXPAND, READY, STREAM}.
  - Forward S-box byte function (the same table the encrypt path uses).
- One sub-module: aes_sub_word, a combinational 32-bit SubWord of 4 forward S-box lookups; one instance.

Test Plan:
- key_load with key 2b7e151628aed2a6abf7158809cf4f3c -> key_ready rises 11 cycles later.
  - dec_start, then rk_ready=1: rk_round 10 gives d014f9a8c9ee2589e13f0cc8b6630ca6; rk_round 1 gives a0fafe1788542cb123a339392a6c7605; rk_round 0 gives the key itself; 11 consecutive beats.
- Same key with rk_ready toggling at random -> rk_out and rk_round are stable while stalled; exactly 11 handshakes; order 10..0.
- key 000102030405060708090a0b0c0d0e0f -> round 10 = 13111d7fe3944a17f307a78b4d2b30c5.
- dec_start during EXPAND is ignored, no rk_valid. key_load during STREAM at rk_round 6 -> rk_valid drops next cycle, key_ready=0, new keys are correct.
- rst_n asserted mid-EXPAND and mid-STREAM -> all outputs 0 asynchronously; a subsequent key_load works normally.
- Second dec_start after a completed stream -> identical 11-key sequence; key_ready stays 1.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES definitions: sizes, round-constant table, forward S-box and
// the key-schedule state encoding.
package aes_pkg;

  localparam int unsigned AES_NR   = 10;
  localparam int unsigned AES_RK_W = 128;

  typedef enum logic [1:0] {
    IDLE,
    EXPAND,
    READY,
    STREAM
  } ks_state_e;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] aes_sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  // Rcon for the expansion step that produces round key idx+1.
  function automatic logic [7:0] aes_rcon(input logic [3:0] idx);
    logic [7:0] rc;
    unique case (idx)
      4'd0:    rc = 8'h01;
      4'd1:    rc = 8'h02;
      4'd2:    rc = 8'h04;
      4'd3:    rc = 8'h08;
      4'd4:    rc = 8'h10;
      4'd5:    rc = 8'h20;
      4'd6:    rc = 8'h40;
      4'd7:    rc = 8'h80;
      4'd8:    rc = 8'h1b;
      4'd9:    rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

endpackage

// File: rtl/aes_sub_word.sv
// Combinational SubWord: four parallel forward S-box lookups.
module aes_sub_word
  import aes_pkg::*;
(
  input  logic [31:0] word_i,
  output logic [31:0] word_o
);

  always_comb begin
    word_o = '0;
    for (int i = 0; i < 4; i++) begin
      word_o[8*i +: 8] = aes_sbox(word_i[8*i +: 8]);
    end
  end

endmodule

// File: rtl/aes_dec_key_schedule.sv
// AES-128 key expansion with a round-key store that is replayed in reverse
// order (round 10 down to 0) over a valid/ready stream.
module aes_dec_key_schedule
  import aes_pkg::*;
#(
  parameter int unsigned NR            = AES_NR,
  parameter bit          CLEAR_ON_LOAD = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                key_load,
  input  logic [AES_RK_W-1:0] key_in,
  output logic                key_ready,
  input  logic                dec_start,
  output logic                rk_valid,
  input  logic                rk_ready,
  output logic [AES_RK_W-1:0] rk_out,
  output logic [3:0]          rk_round,
  output logic                busy
);

  if (NR != AES_NR) begin : gen_nr_check
    $error("aes_dec_key_schedule: only NR = 10 (AES-128) is supported");
  end

  ks_state_e           state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                key_ready_q, key_ready_d;
  logic                rk_valid_q, rk_valid_d;
  logic [AES_RK_W-1:0] rk_out_q, rk_out_d;
  logic [3:0]          rk_round_q, rk_round_d;

  logic [AES_RK_W-1:0] rk_q [NR+1];
  logic                wr_en;
  logic [3:0]          wr_idx;
  logic [AES_RK_W-1:0] wr_data;

  // One expansion step from the most recently written round key.
  logic [AES_RK_W-1:0] prev_rk, next_rk;
  logic [31:0]         w0, w1, w2, w3, w4, w5, w6, w7, rot_w, sub_w;

  assign prev_rk = rk_q[cnt_q];
  assign {w0, w1, w2, w3} = prev_rk;
  assign rot_w = {w3[23:0], w3[31:24]};

  aes_sub_word u_sub_word (
    .word_i (rot_w),
    .word_o (sub_w)
  );

  assign w4 = w0 ^ sub_w ^ {aes_rcon(cnt_q), 24'h0};
  assign w5 = w1 ^ w4;
  assign w6 = w2 ^ w5;
  assign w7 = w3 ^ w6;
  assign next_rk = {w4, w5, w6, w7};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    key_ready_d = key_ready_q;
    rk_valid_d  = rk_valid_q;
    rk_out_d    = rk_out_q;
    rk_round_d  = rk_round_q;
    wr_en       = 1'b0;
    wr_idx      = '0;
    wr_data     = next_rk;

    // A new key overrides everything, including a same-cycle dec_start.
    if (key_load) begin
      state_d     = EXPAND;
      cnt_d       = '0;
      key_ready_d = 1'b0;
      rk_valid_d  = 1'b0;
      wr_en       = 1'b1;
      wr_data     = key_in;
    end else begin
      unique case (state_q)
        IDLE: ;
        EXPAND: begin
          wr_en  = 1'b1;
          wr_idx = cnt_q + 4'd1;
          cnt_d  = cnt_q + 4'd1;
          if (cnt_q == 4'(NR - 1)) begin
            state_d     = READY;
            key_ready_d = 1'b1;
            cnt_d       = '0;
          end
        end
        READY: begin
          if (dec_start) begin
            state_d    = STREAM;
            rk_valid_d = 1'b1;
            rk_round_d = 4'(NR);
            rk_out_d   = rk_q[4'(NR)];
          end
        end
        STREAM: begin
          if (rk_valid_q && rk_ready) begin
            if (rk_round_q == 4'd0) begin
              rk_valid_d = 1'b0;
              state_d    = READY;
            end else begin
              rk_round_d = rk_round_q - 4'd1;
              rk_out_d   = rk_q[rk_round_q - 4'd1];
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      key_ready_q <= 1'b0;
      rk_valid_q  <= 1'b0;
      rk_out_q    <= '0;
      rk_round_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      key_ready_q <= key_ready_d;
      rk_valid_q  <= rk_valid_d;
      rk_out_q    <= rk_out_d;
      rk_round_q  <= rk_round_d;
    end
  end

  if (CLEAR_ON_LOAD) begin : gen_store_clr
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int unsigned i = 0; i <= NR; i++) rk_q[i] <= '0;
      end else begin
        for (int unsigned i = 0; i <= NR; i++) begin
          if (key_load) rk_q[i] <= '0;
          if (wr_en && (wr_idx == 4'(i))) rk_q[i] <= wr_data;
        end
      end
    end
  end else begin : gen_store_keep
    always_ff @(posedge clk) begin
      for (int unsigned i = 0; i <= NR; i++) begin
        if (wr_en && (wr_idx == 4'(i))) rk_q[i] <= wr_data;
      end
    end
  end

  assign key_ready = key_ready_q;
  assign rk_valid  = rk_valid_q;
  assign rk_out    = rk_out_q;
  assign rk_round  = rk_round_q;
  assign busy      = (state_q == EXPAND) || (state_q == STREAM);

endmodule

// File: tb/tb_aes_dec_key_schedule.sv
// Directed and randomized bench for aes_dec_key_schedule against a
// FIPS-197 key-expansion model built from GF(2^8) arithmetic.
module tb_aes_dec_key_schedule;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         key_load = 1'b0;
  logic [127:0] key_in = '0;
  logic         dec_start = 1'b0;
  logic         rk_ready = 1'b0;
  logic         key_ready;
  logic         rk_valid;
  logic [127:0] rk_out;
  logic [3:0]   rk_round;
  logic         busy;

  aes_dec_key_schedule dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_load  (key_load),
    .key_in    (key_in),
    .key_ready (key_ready),
    .dec_start (dec_start),
    .rk_valid  (rk_valid),
    .rk_ready  (rk_ready),
    .rk_out    (rk_out),
    .rk_round  (rk_round),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0]   sbox_m [256];
  logic [127:0] exp_rk [11];
  logic [127:0] obs_rk [11];
  logic [127:0] prev_obs [11];

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ a;
      a = xtime(a);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d = {b, b};
    return d[15-n -: 8];
  endfunction

  // S-box = affine transform of the multiplicative inverse in GF(2^8).
  function automatic void build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endfunction

  function automatic void model_expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]} ^ {rc, 24'h0};
        rc = xtime(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp_v);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk1({tag, "_key_ready"}, key_ready, 1'b0);
    chk1({tag, "_rk_valid"}, rk_valid, 1'b0);
    chk1({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_rk_out"}, rk_out, '0);
    chk({tag, "_rk_round"}, 128'(rk_round), '0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_load(input logic [127:0] key);
    key_in   = key;
    key_load = 1'b1;
    step();
    key_load = 1'b0;
    model_expand(key);
    chk1("load_key_ready", key_ready, 1'b0);
    chk1("load_rk_valid", rk_valid, 1'b0);
    chk1("load_busy", busy, 1'b1);
  endtask

  // Round keys 1..10 land on the next ten edges; key_ready follows the tenth.
  task automatic wait_expand(input int dec_at);
    for (int c = 1; c <= 9; c++) begin
      dec_start = (c == dec_at);
      step();
      chk1("expand_key_ready", key_ready, 1'b0);
      chk1("expand_rk_valid", rk_valid, 1'b0);
    end
    dec_start = 1'b0;
    step();
    chk1("expand_done_key_ready", key_ready, 1'b1);
    chk1("expand_done_busy", busy, 1'b0);
    chk1("expand_done_rk_valid", rk_valid, 1'b0);
  endtask

  task automatic run_stream(input bit rand_ready);
    int exp_round = 10;
    int beats = 0;
    int cyc = 0;
    dec_start = 1'b1;
    step();
    dec_start = 1'b0;
    while (beats < 11 && cyc < 200) begin
      chk1("stream_rk_valid", rk_valid, 1'b1);
      chk1("stream_busy", busy, 1'b1);
      chk("stream_rk_round", 128'(rk_round), 128'(exp_round));
      chk("stream_rk_out", rk_out, exp_rk[exp_round]);
      rk_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rk_ready) obs_rk[10-beats] = rk_out;
      step();
      if (rk_ready) begin
        beats++;
        exp_round--;
      end
      cyc++;
    end
    rk_ready = 1'b0;
    chk("stream_beats", 128'(beats), 128'd11);
    chk1("stream_end_rk_valid", rk_valid, 1'b0);
    chk1("stream_end_busy", busy, 1'b0);
    chk1("stream_end_key_ready", key_ready, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [127:0] k;
    int cyc;
    build_sbox();

    // Reset values.
    rst_n = 1'b0;
    repeat (2) step();
    chk_zero("reset");
    rst_n = 1'b1;

    // dec_start in IDLE has no effect.
    dec_start = 1'b1;
    step();
    dec_start = 1'b0;
    step();
    chk1("idle_dec_rk_valid", rk_valid, 1'b0);
    chk1("idle_dec_busy", busy, 1'b0);

    // FIPS-197 key, full-rate stream.
    pulse_load(128'h2b7e151628aed2a6abf7158809cf4f3c);
    wait_expand(0);
    run_stream(1'b0);
    chk("fips_round10", obs_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    chk("fips_round1", obs_rk[1], 128'ha0fafe1788542cb123a339392a6c7605);
    chk("fips_round0", obs_rk[0], 128'h2b7e151628aed2a6abf7158809cf4f3c);

    // Same keys again with random back-pressure; replay must be identical.
    for (int r = 0; r < 11; r++) prev_obs[r] = obs_rk[r];
    run_stream(1'b1);
    for (int r = 0; r < 11; r++) chk("replay_same_key", obs_rk[r], prev_obs[r]);

    // Second known-answer key; dec_start during EXPAND is ignored.
    pulse_load(128'h000102030405060708090a0b0c0d0e0f);
    wait_expand(4);
    run_stream(1'b1);
    chk("seq_key_round10", obs_rk[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);

    // Random keys with random stalls and dec_start pulses during EXPAND.
    for (int n = 0; n < 3; n++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      pulse_load(k);
      wait_expand(int'($urandom_range(1, 9)));
      run_stream(1'b1);
    end

    // key_load arriving at rk_round 6 abandons the stream.
    pulse_load({$urandom, $urandom, $urandom, $urandom});
    wait_expand(0);
    dec_start = 1'b1;
    step();
    dec_start = 1'b0;
    rk_ready = 1'b1;
    cyc = 0;
    while (rk_round !== 4'd6 && cyc < 20) begin
      step();
      cyc++;
    end
    chk("mid_stream_round", 128'(rk_round), 128'd6);
    chk("mid_stream_rk_out", rk_out, exp_rk[6]);
    pulse_load({$urandom, $urandom, $urandom, $urandom});
    rk_ready = 1'b0;
    wait_expand(0);
    run_stream(1'b1);

    // key_load and dec_start together in READY: the load wins.
    k = {$urandom, $urandom, $urandom, $urandom};
    key_in    = k;
    key_load  = 1'b1;
    dec_start = 1'b1;
    step();
    key_load  = 1'b0;
    dec_start = 1'b0;
    model_expand(k);
    chk1("both_rk_valid", rk_valid, 1'b0);
    chk1("both_key_ready", key_ready, 1'b0);
    chk1("both_busy", busy, 1'b1);
    wait_expand(0);
    run_stream(1'b0);

    // Asynchronous reset in the middle of EXPAND.
    pulse_load({$urandom, $urandom, $urandom, $urandom});
    repeat (3) step();
    #3 rst_n = 1'b0;
    #1 chk_zero("reset_mid_expand");
    #1 rst_n = 1'b1;
    step();
    pulse_load(128'h2b7e151628aed2a6abf7158809cf4f3c);
    wait_expand(0);
    dec_start = 1'b1;
    step();
    dec_start = 1'b0;
    rk_ready = 1'b1;
    repeat (3) step();
    rk_ready = 1'b0;
    chk1("pre_reset_stream_valid", rk_valid, 1'b1);

    // Asynchronous reset in the middle of STREAM.
    #3 rst_n = 1'b0;
    #1 chk_zero("reset_mid_stream");
    #1 rst_n = 1'b1;
    step();
    pulse_load({$urandom, $urandom, $urandom, $urandom});
    wait_expand(0);
    run_stream(1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
